branch_cond_unit: RTL

//  Execute-stage neighbour of the ALU: consumes the ALU's C/Z/N/V flags into a condition-code register (CCR).

---
 rtl/branch_cond_unit_pkg.sv | 49 ++++
 rtl/branch_cond_unit_cond_eval.sv | 62 ++++++
 rtl/branch_cond_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/branch_cond_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package     : branch_cond_unit_pkg
// Description : Shared definitions for the branch condition unit.
//               - VeSPA Bxx condition-field encodings (COND_BRA .. COND_BMI)
//               - CCR bit indices; the ALU flag vector order is {C,Z,N,V},
//                 so C is the MSB and V the LSB.
//               - pack_flags(): builds a flag vector in that order.
// Revision    : 1.0  initial release
// ============================================================================
package branch_cond_unit_pkg;

  // CCR / ALU flag vector bit positions: {C,Z,N,V}
  localparam int CCR_C = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_N = 1;
  localparam int CCR_V = 0;

  // Condition field encodings. Bit 3 inverts the sense of the test in
  // bits 2:0; x111 is reserved.
  localparam logic [3:0] COND_BRA = 4'b0000; // always
  localparam logic [3:0] COND_BNV = 4'b1000; // never
  localparam logic [3:0] COND_BCC = 4'b0001; // ~C
  localparam logic [3:0] COND_BCS = 4'b1001; // C
  localparam logic [3:0] COND_BVC = 4'b0010; // ~V
  localparam logic [3:0] COND_BVS = 4'b1010; // V
  localparam logic [3:0] COND_BEQ = 4'b0011; // Z
  localparam logic [3:0] COND_BNE = 4'b1011; // ~Z
  localparam logic [3:0] COND_BGE = 4'b0100; // ~(N^V)
  localparam logic [3:0] COND_BLT = 4'b1100; // N^V
  localparam logic [3:0] COND_BGT = 4'b0101; // ~(Z|(N^V))
  localparam logic [3:0] COND_BLE = 4'b1101; // Z|(N^V)
  localparam logic [3:0] COND_BPL = 4'b0110; // ~N
  localparam logic [3:0] COND_BMI = 4'b1110; // N

  // Build a flag vector in CCR order from individual ALU flags.
  function automatic logic [3:0] pack_flags(input logic c, input logic z,
                                            input logic n, input logic v);
    logic [3:0] f;
    f        = 4'b0000;
    f[CCR_C] = c;
    f[CCR_Z] = z;
    f[CCR_N] = n;
    f[CCR_V] = v;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cond_unit_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Purely combinational VeSPA branch condition evaluator.
//               Evaluates a 4-bit condition field against a {C,Z,N,V} flag
//               vector. Reserved encodings (x111) report illegal and are
//               never taken.
// Ports       : cond    [3:0] in   condition field
//               flags   [3:0] in   {C,Z,N,V}
//               taken         out  condition true
//               illegal       out  reserved condition code
// Revision    : 1.0  initial release
// ============================================================================
module cond_eval
  import branch_cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken,
  output logic       illegal
);

  logic w_c;
  logic w_z;
  logic w_n;
  logic w_v;
  logic w_lt;   // signed less-than: N xor V

  assign w_c  = flags[CCR_C];
  assign w_z  = flags[CCR_Z];
  assign w_n  = flags[CCR_N];
  assign w_v  = flags[CCR_V];
  assign w_lt = w_n ^ w_v;

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (cond)
      COND_BRA: taken = 1'b1;
      COND_BNV: taken = 1'b0;
      COND_BCC: taken = ~w_c;
      COND_BCS: taken = w_c;
      COND_BVC: taken = ~w_v;
      COND_BVS: taken = w_v;
      COND_BEQ: taken = w_z;
      COND_BNE: taken = ~w_z;
      COND_BGE: taken = ~w_lt;
      COND_BLT: taken = w_lt;
      COND_BGT: taken = ~(w_z | w_lt);
      COND_BLE: taken = w_z | w_lt;
      COND_BPL: taken = ~w_n;
      COND_BMI: taken = w_n;
      default: begin
        // 0111 and 1111
        taken   = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond_unit
// Description : Execute-stage branch condition unit. Latches ALU flags into
//               the condition-code register (CCR), evaluates the Bxx
//               condition field against it, and computes the branch target
//               PC + sext(disp). The result is registered (latency 1) and
//               handed to fetch over a valid/ready handshake; single-entry
//               stage, one result per cycle when the consumer is ready.
// Config      : FLAG_BYPASS_EN - when defined, a request accepted in the
//               same cycle as flag_we is evaluated against the incoming
//               flag_* inputs instead of the registered CCR.
// Ports       : clk, reset (async, active-high)
//               flag_we, flag_c/z/n/v        ALU flag update
//               br_valid/br_ready, br_cond, br_pc, br_disp   request
//               flush                        kill held and incoming request
//               res_valid/res_ready, res_taken, res_target, res_illegal
//               ccr [3:0]                    {C,Z,N,V} readback
// Revision    : 1.0  initial release
// ============================================================================
module branch_cond_unit
  import branch_cond_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DISP_WIDTH = 23
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flag_we,
  input  logic                  flag_c,
  input  logic                  flag_z,
  input  logic                  flag_n,
  input  logic                  flag_v,
  input  logic                  br_valid,
  output logic                  br_ready,
  input  logic [3:0]            br_cond,
  input  logic [ADDR_WIDTH-1:0] br_pc,
  input  logic [DISP_WIDTH-1:0] br_disp,
  input  logic                  flush,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_taken,
  output logic [ADDR_WIDTH-1:0] res_target,
  output logic                  res_illegal,
  output logic [3:0]            ccr
);

  localparam int C_EXT_W = ADDR_WIDTH - DISP_WIDTH;

  logic [3:0]            r_ccr;
  logic                  r_res_valid;
  logic                  r_res_taken;
  logic                  r_res_illegal;
  logic [ADDR_WIDTH-1:0] r_res_target;

  logic [3:0]            w_alu_flags;
  logic [3:0]            w_eval_flags;
  logic                  w_taken;
  logic                  w_illegal;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_disp_sext;
  logic [ADDR_WIDTH-1:0] w_target;

  assign w_alu_flags = pack_flags(flag_c, flag_z, flag_n, flag_v);

  // --------------------------------------------------------------------------
  // Condition-code register. Independent of flush and of the handshake.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ccr <= 4'b0000;
    end else if (flag_we) begin
      r_ccr <= w_alu_flags;
    end
  end

  // Flag source for evaluation. Without the bypass a flag update in the
  // accept cycle is only seen by later requests, so decode must stall one
  // instruction after a flag-setting ALU op.
`ifdef FLAG_BYPASS_EN
  assign w_eval_flags = flag_we ? w_alu_flags : r_ccr;
`else
  assign w_eval_flags = r_ccr;
`endif

  cond_eval u_cond_eval (
    .cond    (br_cond),
    .flags   (w_eval_flags),
    .taken   (w_taken),
    .illegal (w_illegal)
  );

  // Target adder: sign-extend displacement, carry out is discarded so the
  // sum wraps modulo 2^ADDR_WIDTH. Computed regardless of taken.
  assign w_disp_sext = {{C_EXT_W{br_disp[DISP_WIDTH-1]}}, br_disp};
  assign w_target    = br_pc + w_disp_sext;

  // --------------------------------------------------------------------------
  // Handshake. The slot is free when empty or being drained this cycle;
  // flush wins over an incoming request.
  // --------------------------------------------------------------------------
  assign br_ready = ~r_res_valid | res_ready;
  assign w_accept = br_valid & br_ready & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res_valid   <= 1'b0;
      r_res_taken   <= 1'b0;
      r_res_illegal <= 1'b0;
      r_res_target  <= '0;
    end else if (flush) begin
      r_res_valid <= 1'b0;
    end else if (w_accept) begin
      r_res_valid   <= 1'b1;
      r_res_taken   <= w_taken;
      r_res_illegal <= w_illegal;
      r_res_target  <= w_target;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid   = r_res_valid;
  assign res_taken   = r_res_taken;
  assign res_illegal = r_res_illegal;
  assign res_target  = r_res_target;
  assign ccr         = r_ccr;

endmodule
`default_nettype wire
